// File: rtl/adder_pkg.sv
// Shared definitions for the operand loader and the downstream adder:
// FSM state encodings, default field widths and the format word layout.
package adder_pkg;

    // Default operand and format word widths.
    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned FMT_W_DEFAULT  = 4;

    // Format word bit0 selects the number system: 0 = fixed point, 1 = floating point.
    localparam int unsigned FMT_FLOAT_BIT = 0;
    localparam logic        FMT_FIXED     = 1'b0;
    localparam logic        FMT_FLOAT     = 1'b1;

    // Loader FSM states; the encoding is shown directly on the LEDs.
    typedef enum logic [1:0] {
        S_OP1   = 2'd0,
        S_OP2   = 2'd1,
        S_FMT   = 2'd2,
        S_READY = 2'd3
    } state_e;

    // True when a format word requests floating-point operation.
    function automatic logic fmt_is_float(input logic [FMT_W_DEFAULT-1:0] fmt);
        return fmt[FMT_FLOAT_BIT] == FMT_FLOAT;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchroniser and rising-edge detector.
// A three-flop chain s1->s2->s3 retimes the raw button; pulse = s2 & ~s3 gives one
// clock-wide pulse per press, independent of how long the button is held.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // After reset the chain is all zero, so a button held through reset would look
    // like a fresh rising edge. seen_low_q only opens the detector once the button
    // has actually been observed released after reset; primed_q marks that s1_q
    // holds a real post-reset sample rather than its reset value.
    logic primed_q, primed_d;
    logic seen_low_q, seen_low_d;

    // Next-state for the synchroniser chain and release tracking.
    always_comb begin
        s1_d       = btn;
        s2_d       = s1_q;
        s3_d       = s2_q;
        primed_d   = 1'b1;
        seen_low_d = seen_low_q | (primed_q & ~s1_q);
    end

    // Synchroniser state; cleared only by reset, never by the soft clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            primed_q   <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            primed_q   <= primed_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign pulse = s2_q & ~s3_q & seen_low_q;

endmodule

// File: rtl/operand_loader.sv
// Operand loader: captures operand1, operand2 and a format word from the switches,
// one field per debounced button press, and raises start once all three are valid.
// Fields are passed bit-exact; no arithmetic happens here.
module operand_loader
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned FMT_W  = FMT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_btn,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [FMT_W-1:0]  format,
    output logic              start,
    output logic [1:0]        state
);

    logic load_pulse;

    state_e state_q, state_d;
    logic   start_q, start_d;

    logic [DATA_W-1:0] operand1_q, operand1_d;
    logic [DATA_W-1:0] operand2_q, operand2_d;
    logic [FMT_W-1:0]  format_q, format_d;

    btn_sync_edge u_btn_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (load_btn),
        .pulse (load_pulse)
    );

    // FSM next-state: clr beats a simultaneous load; start rises entering S_READY.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        if (clr) begin
            state_d = S_OP1;
            start_d = 1'b0;
        end else if (load_pulse) begin
            case (state_q)
                S_OP1: begin
                    state_d = S_OP2;
                end
                S_OP2: begin
                    state_d = S_FMT;
                end
                S_FMT: begin
                    state_d = S_READY;
                    start_d = 1'b1;
                end
                S_READY: begin
                    // A new press starts the next operation from operand1.
                    state_d = S_OP2;
                    start_d = 1'b0;
                end
                default: begin
                    state_d = S_OP1;
                    start_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered start flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OP1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    // Datapath next-state: the field selected by the current state takes data_in.
    always_comb begin
        operand1_d = operand1_q;
        operand2_d = operand2_q;
        format_d   = format_q;
        if (clr) begin
            operand1_d = '0;
            operand2_d = '0;
            format_d   = '0;
        end else if (load_pulse) begin
            case (state_q)
                S_OP1:   operand1_d = data_in;
                S_OP2:   operand2_d = data_in;
                S_FMT:   format_d   = data_in[FMT_W-1:0];
                S_READY: operand1_d = data_in;
                default: operand1_d = operand1_q;
            endcase
        end
    end

    // Datapath field registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            operand1_q <= '0;
            operand2_q <= '0;
            format_q   <= '0;
        end else begin
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            format_q   <= format_d;
        end
    end

    assign operand1 = operand1_q;
    assign operand2 = operand2_q;
    assign format   = format_q;
    assign start    = start_q;
    assign state    = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: load sequence, capture latency, hold, clr,
// reset mid-sequence, button held through reset and short glitches.
module tb_operand_loader;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load_btn;
    logic [7:0] data_in;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [3:0] format;
    logic       start;
    logic [1:0] state;

    int checks;
    int failures;

    operand_loader #(
        .DATA_W (8),
        .FMT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load_btn (load_btn),
        .data_in  (data_in),
        .operand1 (operand1),
        .operand2 (operand2),
        .format   (format),
        .start    (start),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_op1, input logic [7:0] e_op2,
                             input logic [3:0] e_fmt, input logic e_start, input logic [1:0] e_st);
        check({tag, ".operand1"}, 32'(operand1), 32'(e_op1));
        check({tag, ".operand2"}, 32'(operand2), 32'(e_op2));
        check({tag, ".format"},   32'(format),   32'(e_fmt));
        check({tag, ".start"},    32'(start),    32'(e_start));
        check({tag, ".state"},    32'(state),    32'(e_st));
    endtask

    // Press with data d: the edge that samples the button is edge 1; nothing may
    // change by edge 2 and the capture lands on edge 3. Then release and settle.
    task automatic press(input string tag, input logic [7:0] d, input logic [1:0] st_before);
        data_in  = d;
        load_btn = 1'b1;
        tick();
        tick();
        check({tag, ".not_yet"}, 32'(state), 32'(st_before));
        tick();
        load_btn = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        load_btn = 1'b0;
        data_in  = 8'h00;
        repeat (3) tick();
        check_all("reset", 8'h00, 8'h00, 4'h0, 1'b0, 2'd0);
        rst = 1'b0;
        repeat (3) tick();
        check_all("idle", 8'h00, 8'h00, 4'h0, 1'b0, 2'd0);

        // Full load sequence 0x23, 0x41, 0x01.
        press("op1", 8'h23, 2'd0);
        check_all("op1", 8'h23, 8'h00, 4'h0, 1'b0, 2'd1);
        press("op2", 8'h41, 2'd1);
        check_all("op2", 8'h23, 8'h41, 4'h0, 1'b0, 2'd2);
        press("fmt", 8'h01, 2'd2);
        check_all("ready", 8'h23, 8'h41, 4'h1, 1'b1, 2'd3);
        data_in = 8'hEE;
        repeat (5) tick();
        check_all("ready_hold", 8'h23, 8'h41, 4'h1, 1'b1, 2'd3);

        // New press in S_READY restarts at operand1 and drops start.
        press("reload", 8'h7F, 2'd3);
        check_all("reload", 8'h7F, 8'h41, 4'h1, 1'b0, 2'd1);

        // Reach S_FMT, then clr coincides with the load pulse.
        press("op2b", 8'h99, 2'd1);
        check_all("op2b", 8'h7F, 8'h99, 4'h1, 1'b0, 2'd2);
        data_in  = 8'h0A;
        load_btn = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("clr_vs_load", 8'h00, 8'h00, 4'h0, 1'b0, 2'd0);
        repeat (4) tick();
        check_all("clr_no_replay", 8'h00, 8'h00, 4'h0, 1'b0, 2'd0);
        load_btn = 1'b0;
        repeat (4) tick();

        // Held for 50 cycles in S_OP1: one capture only.
        data_in  = 8'h3C;
        load_btn = 1'b1;
        repeat (5) tick();
        data_in = 8'h11;
        repeat (45) tick();
        check_all("long_hold", 8'h3C, 8'h00, 4'h0, 1'b0, 2'd1);
        load_btn = 1'b0;
        repeat (4) tick();

        // Reset in S_OP2 with operand1 = 0x55, button held through reset.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        press("op1_55", 8'h55, 2'd0);
        check_all("op1_55", 8'h55, 8'h00, 4'h0, 1'b0, 2'd1);
        data_in  = 8'h66;
        load_btn = 1'b1;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check_all("rst_held", 8'h00, 8'h00, 4'h0, 1'b0, 2'd0);
        load_btn = 1'b0;
        repeat (4) tick();
        check_all("rst_release", 8'h00, 8'h00, 4'h0, 1'b0, 2'd0);
        press("after_rst", 8'h12, 2'd0);
        check_all("after_rst", 8'h12, 8'h00, 4'h0, 1'b0, 2'd1);

        // Glitch entirely between two edges: never sampled, no capture.
        data_in  = 8'hA5;
        load_btn = 1'b1;
        #3;
        load_btn = 1'b0;
        repeat (6) tick();
        check_all("glitch_between", 8'h12, 8'h00, 4'h0, 1'b0, 2'd1);

        // One-cycle glitch spanning an edge: exactly one capture.
        load_btn = 1'b1;
        tick();
        load_btn = 1'b0;
        repeat (6) tick();
        check_all("glitch_one", 8'h12, 8'hA5, 4'h0, 1'b0, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
